// File: rtl/fsm_defs.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fsm_defs                                                       |
// | State encoding shared by the tick event counter control FSM.   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package fsm_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tick_event_counter_rise_detect.sv
`default_nettype none
// +----------------------------------------------------------------+
// | rise_detect                                                    |
// | One-flop rising-edge detector for synchronous strobes.         |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic r_in_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_q <= 1'b0;
    end else begin
      r_in_q <= in;
    end
  end

  assign pulse = in & ~r_in_q;

endmodule
`default_nettype wire

// File: rtl/tick_event_counter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tick_event_counter                                             |
// | Counts rising edges of a divided strobe up to a captured limit.|
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module tick_event_counter
  import fsm_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  state_t           w_state_d;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_d;
  logic [WIDTH-1:0] r_limit;
  logic [WIDTH-1:0] w_limit_d;
  logic [WIDTH-1:0] w_count_inc;
  logic             w_edge;
  logic             r_busy;
  logic             r_done;

  rise_detect u_rise_detect (
    .clk   (clk),
    .reset (reset),
    .in    (tick_in),
    .pulse (w_edge)
  );

  assign w_count_inc = r_count + 1'b1;

  always_comb begin
    w_state_d = r_state;
    w_count_d = r_count;
    w_limit_d = r_limit;
    unique case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_limit_d = limit;
          w_count_d = '0;
          w_state_d = S_RUN;
        end
      end
      S_RUN: begin
        // stop beats everything; a zero limit finishes without counting
        if (stop) begin
          w_state_d = S_IDLE;
        end else if (r_limit == '0) begin
          w_state_d = S_DONE;
        end else if (w_edge) begin
          w_count_d = w_count_inc;
          if (w_count_inc == r_limit) begin
            w_state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_d = S_IDLE;
      end
      default: begin
        w_state_d = S_IDLE;
      end
    endcase
  end

  // busy/done are decoded from the next state so they leave a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_limit <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      r_limit <= w_limit_d;
      r_busy  <= (w_state_d == S_RUN);
      r_done  <= (w_state_d == S_DONE);
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tick_event_counter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_tick_event_counter                                          |
// | Randomised scoreboard bench for tick_event_counter.            |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module tb_tick_event_counter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick_in;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  typedef struct packed {
    logic             exp_done;
    logic [WIDTH-1:0] exp_count;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_tick = 1'b0;

  tick_event_counter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .tick_in (tick_in),
    .start   (start),
    .stop    (stop),
    .limit   (limit),
    .count   (count),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // one clock of stimulus; reset clears the DUT's tick history
  task automatic drive(logic t, logic s, logic p, logic [WIDTH-1:0] l);
    tick_in = t;
    start   = s;
    stop    = p;
    limit   = l;
    @(posedge clk);
    #1;
    prev_tick = reset ? 1'b0 : t;
  endtask

  task automatic idle_gap(int n);
    for (int i = 0; i < n; i++) begin
      drive(1'(($urandom_range(0, 1))), 1'b0, 1'(($urandom_range(0, 1))), WIDTH'($urandom));
    end
  endtask

  // mode: 0 random, 1 one-in-three strobe, 2 toggle, 3 held high 5 cycles
  task automatic do_run(int lim, int mode, int stop_pct, int budget);
    int   c;
    bit   ended;
    logic t;
    logic p;
    int   phase;
    c     = 0;
    ended = 1'b0;
    phase = $urandom_range(0, 2);
    t     = (mode == 3) ? 1'b0 : 1'(($urandom_range(0, 1)));
    drive(t, 1'b1, 1'b0, lim[WIDTH-1:0]);
    check("start_busy", busy, 1);
    for (int j = 0; j < budget && !ended; j++) begin
      case (mode)
        0:       t = 1'(($urandom_range(0, 1)));
        1:       t = (((j + phase) % 3) == 0);
        2:       t = ((j % 2) == 0);
        default: t = (j >= 1 && j <= 5);
      endcase
      p = ($urandom_range(0, 99) < stop_pct) || (j == budget - 1);
      if (p) begin
        ended = 1'b1;
        exp_q.push_back('{exp_done: 1'b0, exp_count: WIDTH'(c)});
      end else if (lim == 0) begin
        ended = 1'b1;
        exp_q.push_back('{exp_done: 1'b1, exp_count: '0});
      end else if (t && !prev_tick) begin
        c++;
        if (c == lim) begin
          ended = 1'b1;
          exp_q.push_back('{exp_done: 1'b1, exp_count: WIDTH'(c)});
        end
      end
      drive(t, 1'(($urandom_range(0, 1))), p, WIDTH'($urandom));
      check("run_count", count, c);
      check("run_busy", busy, {31'd0, !ended});
    end
    start = 1'b0;
    idle_gap(3);
  endtask

  // scoreboard monitor: every end of a run must match the next expectation
  initial begin : monitor
    logic pb;
    exp_t e;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (pb === 1'b1 && busy === 1'b0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_end: count=%0d done=%0d with no expectation", count, done);
        end else begin
          e = exp_q.pop_front();
          check("end_count", count, e.exp_count);
          check("end_done", done, e.exp_done);
        end
      end else if (done !== 1'b0 && reset === 1'b0) begin
        check("stray_done", done, 0);
      end
      pb = busy;
    end
  end

  initial begin
    reset   = 1'b1;
    tick_in = 1'b1;
    start   = 1'b1;
    stop    = 1'b0;
    limit   = 8'd7;
    drive(1'b1, 1'b1, 1'b0, 8'd7);
    drive(1'b1, 1'b1, 1'b0, 8'd7);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    check("reset_count", count, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    check("reset_idle", busy, 0);

    do_run(4, 1, 0, 40);
    do_run(3, 3, 0, 8);
    do_run(5, 1, 0, 7);
    do_run(0, 0, 0, 10);
    do_run(1, 2, 0, 10);
    do_run(255, 2, 0, 600);

    // stop asserted together with an edge: that edge is not counted
    drive(1'b0, 1'b1, 1'b0, 8'd5);
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    exp_q.push_back('{exp_done: 1'b0, exp_count: 8'd2});
    drive(1'b1, 1'b0, 1'b1, 8'd0);
    check("stop_edge_count", count, 2);
    idle_gap(3);

    // reset coincident with the limit edge
    drive(1'b0, 1'b1, 1'b0, 8'd2);
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    check("pre_reset_count", count, 1);
    exp_q.push_back('{exp_done: 1'b0, exp_count: 8'd0});
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    check("midrun_reset_count", count, 0);
    check("midrun_reset_busy", busy, 0);
    check("midrun_reset_done", done, 0);

    // start and stop together in IDLE
    drive(1'b0, 1'b1, 1'b1, 8'd5);
    check("start_stop_busy", busy, 0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    check("start_stop_idle", busy, 0);

    for (int r = 0; r < 30; r++) begin
      do_run($urandom_range(0, 12), $urandom_range(0, 2), $urandom_range(0, 3), 80);
    end

    idle_gap(4);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
